// File: rtl/llc_lookup_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// llc_lookup_ctrl_pkg
// Shared LLC cache constants and types used by the lookup sequencer and its
// arbiter: tag/set/way types, the way count, and the sequencer FSM enum.
// ---------------------------------------------------------------------------
package llc_lookup_ctrl_pkg;

  localparam int LLC_TAG_BITS = 20;
  localparam int LLC_SET_BITS = 8;
  localparam int LLC_WAY_BITS = 3;
  localparam int LLC_WAYS     = 1 << LLC_WAY_BITS;

  typedef logic [LLC_TAG_BITS-1:0] llc_tag_t;
  typedef logic [LLC_SET_BITS-1:0] llc_set_t;
  typedef logic [LLC_WAY_BITS-1:0] llc_way_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_BUF = 3'd2,
    CAPTURE  = 3'd3,
    RESP     = 3'd4
  } llc_lookup_ctrl_state_t;

endpackage

// File: rtl/llc_lookup_ctrl_rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Round-robin arbiter. The search starts one past the last granted requester
// and wraps modulo NUM_REQ. The grant is purely combinational; last_grant is
// updated only when a grant is actually issued (en high and a request seen).
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   req        : request vector
//   en         : arbitration enable (grant forced to zero when low)
//   gnt        : one-hot grant
//   gnt_idx    : index of the granted requester
// ---------------------------------------------------------------------------
module rr_arb #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    // NOTE: every combinational output gets a default before any branch, so
    // no path can leave it unassigned and infer a latch.
    found        = 1'b0;
    cand         = '0;
    gnt          = '0;
    gnt_idx      = '0;
    last_grant_d = last_grant_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
        last_grant_d = cand;
      end
    end
  end

  // Reset to the last requester so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/llc_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// llc_lookup_ctrl
// Sequencer for the LLC way-lookup datapath: arbitrates between NUM_REQ
// requesters, loads the set buffers, fires a single-cycle lookup, captures the
// way/evict result, advances the eviction pointer on eviction and returns the
// result on a valid/ready response channel. One lookup in flight at a time.
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   req_valid/req_ready/req_tag/req_set : requester side (ready = one-hot grant)
//   bufs_load/bufs_set/bufs_valid  : set buffer load request and status
//   lookup_en/lookup_tag           : lookup-way datapath control
//   lk_way/lk_evict                : registered datapath result
//   evict_way_wr_en/_wr_data       : eviction pointer update
//   resp_valid/resp_ready/resp_id/resp_way/resp_evict : response channel
// Optional macro LLC_LOOKUP_STATS_EN adds saturating stat_lookups/stat_evicts.
// ---------------------------------------------------------------------------
module llc_lookup_ctrl
  import llc_lookup_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  llc_tag_t           req_tag [NUM_REQ],
  input  llc_set_t           req_set [NUM_REQ],
  output logic               bufs_load,
  output llc_set_t           bufs_set,
  input  logic               bufs_valid,
  output logic               lookup_en,
  output llc_tag_t           lookup_tag,
  input  llc_way_t           lk_way,
  input  logic               lk_evict,
  output logic               evict_way_wr_en,
  output llc_way_t           evict_way_wr_data,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_BITS-1:0] resp_id,
  output llc_way_t           resp_way,
  output logic               resp_evict
`ifdef LLC_LOOKUP_STATS_EN
  ,
  output logic [31:0]        stat_lookups,
  output logic [31:0]        stat_evicts
`endif
);

  llc_lookup_ctrl_state_t state_q, state_d;
  llc_tag_t               tag_q, tag_d;
  llc_set_t               set_q, set_d;
  logic [ID_BITS-1:0]     id_q, id_d;
  llc_way_t               way_q, way_d;
  logic                   evict_q, evict_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [ID_BITS-1:0]     arb_idx;

  // Arbitrate only in IDLE; rst also gates the enable so req_ready is low
  // while reset is asserted even with requests pending.
  rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_BITS)
  ) u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      ((state_q == IDLE) && rst),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign req_ready  = arb_gnt;
  assign bufs_set   = set_q;
  assign lookup_tag = tag_q;
  assign resp_id    = id_q;
  assign resp_way   = way_q;
  assign resp_evict = evict_q;

  always_comb begin
    state_d           = state_q;
    tag_d             = tag_q;
    set_d             = set_q;
    id_d              = id_q;
    way_d             = way_q;
    evict_d           = evict_q;
    bufs_load         = 1'b0;
    lookup_en         = 1'b0;
    evict_way_wr_en   = 1'b0;
    evict_way_wr_data = '0;
    resp_valid        = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          tag_d   = req_tag[arb_idx];
          set_d   = req_set[arb_idx];
          id_d    = arb_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // bufs_valid is deliberately ignored here; lookup issues from WAIT_BUF.
        bufs_load = 1'b1;
        state_d   = WAIT_BUF;
      end
      WAIT_BUF: begin
        if (bufs_valid) begin
          lookup_en = 1'b1;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        way_d   = lk_way;
        evict_d = lk_evict;
        if (lk_evict) begin
          evict_way_wr_en   = 1'b1;
          // Natural wrap at LLC_WAY_BITS: the last way advances to way 0.
          evict_way_wr_data = llc_way_t'(lk_way + 1'b1);
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: only control and output-visible registers exist here, and all of
  // them are reset so a mid-lookup reset leaves no stale response behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
      set_q   <= '0;
      id_q    <= '0;
      way_q   <= '0;
      evict_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      id_q    <= id_d;
      way_q   <= way_d;
      evict_q <= evict_d;
    end
  end

`ifdef LLC_LOOKUP_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_evicts_q, stat_evicts_d;

  // Saturating event counters.
  always_comb begin
    stat_lookups_d = stat_lookups_q;
    stat_evicts_d  = stat_evicts_q;
    if (lookup_en && (stat_lookups_q != 32'hFFFF_FFFF))
      stat_lookups_d = stat_lookups_q + 32'd1;
    if (evict_way_wr_en && (stat_evicts_q != 32'hFFFF_FFFF))
      stat_evicts_d = stat_evicts_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_lookups_q <= '0;
      stat_evicts_q  <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_evicts_q  <= stat_evicts_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_evicts  = stat_evicts_q;
`else
  // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: doc/llc_lookup_ctrl.md
# llc_lookup_ctrl

Sequencer for the LLC way-lookup datapath. It arbitrates round-robin between `NUM_REQ` lookup requesters and loads the tag/state buffers for the winning set. It then fires the single-cycle way lookup, captures the registered `way`/`evict` result, and advances the per-set eviction pointer on eviction. It returns the result through a valid/ready response channel. It sits between the LLC front-end request queues and the lookup-way datapath and set buffers.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of lookup requesters.
- `ID_BITS`, default 2: width of the requester index, equal to $clog2(NUM_REQ).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester lookup request.
- `req_ready` out `NUM_REQ`: one-hot grant; the request is accepted in the cycle where valid and ready are both high.
- `req_tag[NUM_REQ]` in `llc_tag_t`: tag to look up.
- `req_set[NUM_REQ]` in `llc_set_t`: set index.
- `bufs_load` out 1: one-cycle pulse requesting the tags/states/evict_way buffers for `bufs_set`.
- `bufs_set` out `llc_set_t`: set to load. Held stable from the grant until the controller returns to IDLE.
- `bufs_valid` in 1: buffers for `bufs_set` are stable and valid.
- `lookup_en` out 1: enable for the lookup-way datapath.
- `lookup_tag` out `llc_tag_t`: latched request tag.
- `lk_way` in `llc_way_t`: registered way from the datapath.
- `lk_evict` in 1: registered evict flag from the datapath.
- `evict_way_wr_en` out 1: write strobe for the set's eviction pointer.
- `evict_way_wr_data` out `llc_way_t`: new eviction pointer value.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer accepts the response.
- `resp_id` out `ID_BITS`: index of the granted requester.
- `resp_way` out `llc_way_t`: selected way.
- `resp_evict` out 1: the selected way requires eviction.

## Operation
- FSM states are IDLE, LOAD, WAIT_BUF, CAPTURE and RESP.
- **IDLE:** if any `req_valid` is high, the round-robin arbiter grants one requester.
  - Search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - `req_ready` is combinational, high only for the granted bit, and only in IDLE.
  - On grant, latch tag, set and id, update `last_grant`, and go to LOAD.
- **LOAD:** `bufs_load`=1 for exactly this cycle, then go to WAIT_BUF.
- **WAIT_BUF:** stay until `bufs_valid`=1. In that cycle `lookup_en`=1 (one cycle only), then go to CAPTURE.
- **CAPTURE:** sample `lk_way` and `lk_evict` into the response registers.
  - If `lk_evict`=1, `evict_way_wr_en`=1 and `evict_way_wr_data`=(`lk_way`+1) mod `LLC_WAYS`. This is natural wrap at `LLC_WAY_BITS`, so `LLC_WAYS`-1 becomes 0.
  - Go to RESP.
- **RESP:** `resp_valid`=1 with the response fields held stable until `resp_ready`=1. On the handshake cycle, go to IDLE.
- Only one lookup is in flight at a time. Requesters that are not granted keep `req_valid` asserted and are not reordered.
- New requests that arrive while the controller is busy wait until the next IDLE cycle.

## Timing
- Reset values:
  - FSM state is IDLE.
  - `last_grant` = `NUM_REQ`-1, so requester 0 has highest priority first.
  - All outputs are 0: `req_ready`, `bufs_load`, `bufs_set`, `lookup_en`, `lookup_tag`, `evict_way_wr_en`, `evict_way_wr_data`, `resp_valid`, `resp_id`, `resp_way`, `resp_evict`.
- Reset mid-operation aborts the lookup. No pointer write and no response occur.
- Minimum latency, with `bufs_valid` already high and grant at cycle T:
  - `bufs_load` at T+1.
  - `lookup_en` at T+2.
  - `evict_way_wr_en` at T+3.
  - `resp_valid` at T+4.
- With `resp_ready` held high, the next grant happens at T+5. This gives a throughput of one lookup per 5 cycles.
- `bufs_valid` high in LOAD is ignored. The lookup is issued only from WAIT_BUF.
- `resp_ready` high outside RESP is ignored.
- Simultaneous requests are resolved by round-robin only. Validity of the set is not a factor.

## Configuration
- Macro `LLC_LOOKUP_STATS_EN`.
- When defined, the block adds these outputs:
  - `stat_lookups` (32 bits): increments on every `lookup_en`.
  - `stat_evicts` (32 bits): increments on every `evict_way_wr_en`.
  - Both counters reset to 0 and saturate at 32'hFFFFFFFF.
- When undefined, the ports and counters are absent and the block's behaviour is otherwise identical.

## Structure
- Add `llc_lookup_ctrl_state_t`, the FSM enum, to the shared cache types package.
- `llc_tag_t`, `llc_set_t`, `llc_way_t`, `LLC_WAYS` and `LLC_WAY_BITS` come from the existing shared constants and types.
- One sub-module, `rr_arb`, parameterised by `NUM_REQ`:
  - Inputs are the request vector and the enable; outputs are the one-hot grant and the grant index.
  - It owns the `last_grant` register.

## Test plan
- Single request: `req_valid`=001, tag=0x12, set=5, `bufs_valid`=1, `lk_way`=3, `lk_evict`=0 -> `bufs_set`=5; `lookup_en` at T+2; `resp_valid` at T+4 with id=0, way=3, evict=0; no pointer write.
- Evict with wrap: `lk_evict`=1, `lk_way`=`LLC_WAYS`-1 -> `evict_way_wr_en`=1 and `evict_way_wr_data`=0 at T+3; `resp_evict`=1.
- Round-robin: `req_valid`=111 held constant -> grants in the order 0,1,2,0, with each `resp_id` matching.
- Stall paths: `bufs_valid` low for 4 cycles, then `resp_ready` low for 3 cycles -> `lookup_en` fires once, only after `bufs_valid` rises; response fields stay stable; no new grant occurs until the handshake.
- Reset in WAIT_BUF -> all outputs are 0 immediately; the next request is granted to requester 0 with no stale response.
- With `LLC_LOOKUP_STATS_EN` defined: 3 lookups, 1 of which evicts -> `stat_lookups`=3 and `stat_evicts`=1.
